// File: rtl/fir_mac_sequencer.sv
// One shared MAC walks NTAPS taps per accepted sample; result valid NTAPS cycles after accept.
// Backpressure: s_ready only in IDLE; result held in OUT until m_ready, new samples stalled meanwhile.
module fir_mac_sequencer #(
  parameter int            NTAPS     = 40,
  parameter int            DW        = 8,
  parameter int            CW        = 8,
  parameter int            AW        = 32,
  parameter logic [CW-1:0] COEF_INIT = CW'(100)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          coef_we,
  input  logic [7:0]    coef_addr,
  input  logic [CW-1:0] coef_wdata,
  output logic          coef_err,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] m_data,
  output logic          busy
);
  localparam int            PW   = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [PW:0]   NT_W = (PW+1)'(NTAPS);
  localparam logic [PW-1:0] LAST = PW'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nxt;

  logic [DW-1:0]    hist [NTAPS];
  logic [CW-1:0]    coef [NTAPS];
  logic [PW-1:0]    wr_ptr, newest, k, rd_idx;
  logic [PW:0]      rd_sum;
  logic [AW-1:0]    acc, acc_sum;
  logic [CW+DW-1:0] prod;
  logic             last_tap, coef_ok;

  assign s_ready  = (state == IDLE);
  assign busy     = !s_ready;
  assign m_valid  = (state == OUT);
  assign last_tap = (k == LAST);
  assign coef_ok  = coef_we && s_ready && (coef_addr < 8'(NTAPS));

  // Tap k reads the sample k steps older than the newest, wrapping around the circular history.
  always_comb begin
    rd_sum = {1'b0, newest} + NT_W - {1'b0, k};
    if (rd_sum >= NT_W) rd_sum = rd_sum - NT_W;
    rd_idx  = rd_sum[PW-1:0];
    prod    = (CW+DW)'(coef[k]) * (CW+DW)'(hist[rd_idx]);
    acc_sum = acc + AW'(prod);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid)  state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = OUT;
      OUT:     if (m_ready)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= COEF_INIT;
      end
      wr_ptr   <= '0;
      newest   <= '0;
      k        <= '0;
      acc      <= '0;
      m_data   <= '0;
      coef_err <= 1'b0;
    end else begin
      coef_err <= coef_we && !coef_ok;
      if (coef_ok) coef[coef_addr[PW-1:0]] <= coef_wdata;
      case (state)
        IDLE: if (s_valid) begin
          hist[wr_ptr] <= s_data;
          newest       <= wr_ptr;
          wr_ptr       <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
          acc          <= '0;
          k            <= '0;
        end
        MAC: begin
          acc <= acc_sum;
          k   <= k + PW'(1);
          if (last_tap) m_data <= acc_sum;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomized and directed stimulus against a sum-of-products FIR model of the sequencer.
module tb_fir_mac_sequencer;
  localparam int NTAPS = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid, s_ready, coef_we, coef_err, m_valid, m_ready, busy;
  logic [7:0]  s_data, coef_addr, coef_wdata;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.NTAPS(NTAPS), .DW(8), .CW(8), .AW(32), .COEF_INIT(8'd100)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: y[n] = sum over taps i of coef[i] * x[n-i], missing history reads as 0.
  int          mc [NTAPS];
  int          mh [$];
  bit          m_idle = 1'b1;
  int          mac_left = 0;
  bit          e_valid = 1'b0;
  bit          e_err = 1'b0;
  logic [31:0] e_data = '0;
  logic [31:0] y_pend = '0;
  logic [31:0] out_q [$];

  function automatic logic [31:0] model_y();
    longint s = 0;
    for (int i = 0; i < mh.size(); i++) s += longint'(mc[i]) * longint'(mh[i]);
    return 32'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NTAPS; i++) mc[i] = 100;
    mh.delete();
    m_idle   = 1'b1;
    mac_left = 0;
    e_valid  = 1'b0;
    e_err    = 1'b0;
    e_data   = '0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      e_err = 1'b0;
      if (coef_we) begin
        if (m_idle && int'(coef_addr) < NTAPS) mc[coef_addr] = int'(coef_wdata);
        else e_err = 1'b1;
      end
      if (m_idle) begin
        if (s_valid) begin
          mh.push_front(int'(s_data));
          if (mh.size() > NTAPS) void'(mh.pop_back());
          y_pend   = model_y();
          m_idle   = 1'b0;
          mac_left = NTAPS;
        end
      end else if (mac_left > 0) begin
        mac_left--;
        if (mac_left == 0) begin
          e_valid = 1'b1;
          e_data  = y_pend;
        end
      end else if (m_ready) begin
        e_valid = 1'b0;
        m_idle  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("s_ready", s_ready, m_idle);
    check("busy", busy, !m_idle);
    check("m_valid", m_valid, e_valid);
    check("m_data", m_data, e_data);
    check("coef_err", coef_err, e_err);
    if (m_valid && m_ready) out_q.push_back(m_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'(d);
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    s_valid = 1'b0;
    check("send_accept", ok, 1);
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 5000 && out_q.size() < n; t++) @(posedge clk);
    #1;
    check("wait_out", out_q.size(), n);
  endtask

  task automatic coef_write(input int addr, input int val, output bit err);
    coef_we    = 1'b1;
    coef_addr  = 8'(addr);
    coef_wdata = 8'(val);
    tick();
    coef_we = 1'b0;
    @(negedge clk);
    err = coef_err;
    tick();
  endtask

  task automatic load_coefs(input int idx, input int val);
    bit err;
    for (int i = 0; i < NTAPS; i++) coef_write(i, (i == idx) ? val : 0, err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit err;
    int lat;
    s_valid = 1'b0; s_data = '0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    tick();

    // Impulse
    out_q.delete();
    send(100);
    for (int i = 0; i < 40; i++) send(0);
    wait_out(41);
    check("imp_y1", out_q[0], 10000);
    check("imp_y40", out_q[39], 10000);
    check("imp_y41", out_q[40], 0);

    // Step, wraps the history pointer
    out_q.delete();
    repeat (45) send(100);
    wait_out(45);
    check("step_y1", out_q[0], 10000);
    check("step_y20", out_q[19], 200000);
    check("step_y40", out_q[39], 400000);
    check("step_y45", out_q[44], 400000);

    // Backpressure
    out_q.delete();
    m_ready = 1'b0;
    send(7);
    for (int t = 0; t < 200 && !m_valid; t++) tick();
    repeat (10) tick();
    @(negedge clk);
    check("bp_m_valid", m_valid, 1);
    check("bp_m_data", m_data, 390700);
    check("bp_s_ready", s_ready, 0);
    tick();
    m_ready = 1'b1;
    wait_out(1);
    check("bp_y", out_q[0], 390700);

    // Coefficient load and rejected writes
    load_coefs(0, 1);
    out_q.delete();
    send(5);
    send(7);
    wait_out(2);
    check("cl_y5", out_q[0], 5);
    check("cl_y7", out_q[1], 7);
    send(9);
    coef_write(0, 77, err);
    check("err_in_mac", err, 1);
    wait_out(3);
    coef_write(40, 77, err);
    check("err_addr40", err, 1);
    coef_write(1, 0, err);
    check("ok_write", err, 0);
    send(3);
    wait_out(4);
    check("cl_y9", out_q[2], 9);
    check("cl_y3", out_q[3], 3);

    // Delay tap
    do_reset();
    load_coefs(3, 2);
    out_q.delete();
    for (int i = 1; i <= 5; i++) send(i);
    wait_out(5);
    check("dt_y1", out_q[0], 0);
    check("dt_y2", out_q[1], 0);
    check("dt_y3", out_q[2], 0);
    check("dt_y4", out_q[3], 2);
    check("dt_y5", out_q[4], 4);

    // Reset mid-MAC
    do_reset();
    out_q.delete();
    send(50);
    repeat (20) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_m_valid", m_valid, 0);
    tick();
    rst_n = 1'b1;
    repeat (60) tick();
    check("rst_no_output", out_q.size(), 0);
    send(100);
    lat = 0;
    while (!m_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("latency", lat, NTAPS);
    wait_out(1);
    check("rst_imp_y", out_q[0], 10000);

    // Random traffic
    out_q.delete();
    for (int c = 0; c < 2500; c++) begin
      s_valid    = ($urandom_range(0, 1) == 1);
      s_data     = 8'($urandom_range(0, 255));
      m_ready    = ($urandom_range(0, 3) != 0);
      coef_we    = ($urandom_range(0, 7) == 0);
      coef_addr  = 8'($urandom_range(0, 47));
      coef_wdata = 8'($urandom_range(0, 255));
      tick();
    end
    s_valid = 1'b0;
    coef_we = 1'b0;
    m_ready = 1'b1;
    repeat (100) tick();
    check("rand_has_outputs", out_q.size() > 10, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
